// File: rtl/fft_stp_pkg.sv
// Shared types for the FFT input-path serial-to-parallel controller.
// Holds the controller state encoding and the bit counter width helper.
package fft_stp_pkg;

  typedef enum logic [1:0] {
    SHIFT = 2'd0,
    LOAD  = 2'd1,
    STALL = 2'd2
  } stp_state_t;

  // The counter must hold 0..NUM_BITS-1; the extra headroom keeps it simple.
  function automatic int bit_cnt_width(input int num_bits);
    return $clog2(num_bits + 1);
  endfunction

endpackage

// File: rtl/flex_stp_sr.sv
// Flexible serial-to-parallel shift register with selectable shift direction.
// Contents reset to all ones on the active-low asynchronous reset.
module flex_stp_sr #(
  parameter int NUM_BITS  = 4,
  parameter bit SHIFT_MSB = 1'b1
) (
  input  logic                clk,
  input  logic                n_rst,
  input  logic                shift_enable,
  input  logic                serial_in,
  output logic [NUM_BITS-1:0] parallel_out
);

  // MSB mode shifts toward the MSB so the first bit received ends up on top.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      parallel_out <= '1;
    end else if (shift_enable) begin
      if (SHIFT_MSB) begin
        parallel_out <= {parallel_out[NUM_BITS-2:0], serial_in};
      end else begin
        parallel_out <= {serial_in, parallel_out[NUM_BITS-1:1]};
      end
    end
  end

endmodule

// File: rtl/stp_word_ctrl.sv
// Sequences a flex_stp_sr into whole words and hands them to a one-entry
// valid/ready output register, with frame resync and a completed-word counter.
module stp_word_ctrl
  import fft_stp_pkg::*;
#(
  parameter int NUM_BITS  = 16,
  parameter bit SHIFT_MSB = 1'b1,
  parameter int CNT_W     = 16
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                bit_in,
  input  logic                bit_valid,
  output logic                bit_ready,
  input  logic                frame_sync,
  output logic [NUM_BITS-1:0] word_out,
  output logic                word_valid,
  input  logic                word_ready,
  output logic [CNT_W-1:0]    word_count
);

  localparam int BCNT_W = bit_cnt_width(NUM_BITS);
  localparam logic [BCNT_W-1:0] LAST_BIT = BCNT_W'(NUM_BITS - 1);

  stp_state_t          state;
  stp_state_t          next_state;
  logic [BCNT_W-1:0]   bit_cnt;
  logic [BCNT_W-1:0]   next_bit_cnt;
  logic [NUM_BITS-1:0] parallel_out;
  logic                accept;
  logic                out_free;
  logic                capture;

  assign accept   = bit_valid && bit_ready;
  assign out_free = !word_valid || word_ready;
  assign capture  = (state != SHIFT) && out_free;

  flex_stp_sr #(
    .NUM_BITS  (NUM_BITS),
    .SHIFT_MSB (SHIFT_MSB)
  ) u_sr (
    .clk          (clk),
    .n_rst        (~rst),
    .shift_enable (accept),
    .serial_in    (bit_in),
    .parallel_out (parallel_out)
  );

  always_comb begin
    next_state   = state;
    next_bit_cnt = bit_cnt;
    bit_ready    = 1'b0;
    case (state)
      SHIFT: begin
        bit_ready = 1'b1;
        // A resync wins over word completion; an accepted bit becomes bit 0.
        if (frame_sync) begin
          next_bit_cnt = accept ? BCNT_W'(1) : '0;
        end else if (accept) begin
          if (bit_cnt == LAST_BIT) begin
            next_bit_cnt = '0;
            next_state   = LOAD;
          end else begin
            next_bit_cnt = bit_cnt + BCNT_W'(1);
          end
        end
      end
      LOAD:    next_state = capture ? SHIFT : STALL;
      STALL:   next_state = capture ? SHIFT : STALL;
      default: next_state = SHIFT;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= SHIFT;
      bit_cnt <= '0;
    end else begin
      state   <= next_state;
      bit_cnt <= next_bit_cnt;
    end
  end

  // Output register: a capture refreshes the entry even while it is being consumed.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      word_out   <= '0;
      word_valid <= 1'b0;
      word_count <= '0;
    end else if (capture) begin
      word_out   <= parallel_out;
      word_valid <= 1'b1;
      word_count <= word_count + CNT_W'(1);
    end else if (word_ready) begin
      word_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_stp_word_ctrl.sv
// Bench for stp_word_ctrl: two instances (MSB-first with a 2-bit counter,
// LSB-first with a 16-bit counter) share stimulus and a word-level model.
module tb_stp_word_ctrl;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic bit_in = 1'b0;
  logic bit_valid = 1'b0;
  logic frame_sync = 1'b0;
  logic word_ready = 1'b0;

  logic        bit_ready_a, word_valid_a;
  logic [7:0]  word_out_a;
  logic [1:0]  word_count_a;
  logic        bit_ready_b, word_valid_b;
  logic [7:0]  word_out_b;
  logic [15:0] word_count_b;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  stp_word_ctrl #(.NUM_BITS(8), .SHIFT_MSB(1'b1), .CNT_W(2)) u_a (
    .clk(clk), .rst(rst), .bit_in(bit_in), .bit_valid(bit_valid),
    .bit_ready(bit_ready_a), .frame_sync(frame_sync), .word_out(word_out_a),
    .word_valid(word_valid_a), .word_ready(word_ready), .word_count(word_count_a)
  );

  stp_word_ctrl #(.NUM_BITS(8), .SHIFT_MSB(1'b0), .CNT_W(16)) u_b (
    .clk(clk), .rst(rst), .bit_in(bit_in), .bit_valid(bit_valid),
    .bit_ready(bit_ready_b), .frame_sync(frame_sync), .word_out(word_out_b),
    .word_valid(word_valid_b), .word_ready(word_ready), .word_count(word_count_b)
  );

  // Reference model: partial word as a bit list, one pending completed word,
  // and the output entry.
  bit          part[$];
  bit          m_pend;
  logic [7:0]  p_msb, p_lsb;
  bit          m_ov;
  logic [7:0]  m_msb, m_lsb;
  int unsigned m_cnt;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    part.delete();
    m_pend = 1'b0;
    m_ov   = 1'b0;
    m_msb  = '0;
    m_lsb  = '0;
    m_cnt  = 0;
  endtask

  task automatic model_update();
    if (m_pend) begin
      if (!m_ov || word_ready) begin
        m_ov   = 1'b1;
        m_msb  = p_msb;
        m_lsb  = p_lsb;
        m_cnt  = m_cnt + 1;
        m_pend = 1'b0;
      end
    end else begin
      if (m_ov && word_ready) m_ov = 1'b0;
      if (frame_sync) part.delete();
      if (bit_valid) begin
        part.push_back(bit_in);
        if (part.size() == 8) begin
          p_msb = '0;
          p_lsb = '0;
          for (int i = 0; i < 8; i++) begin
            p_msb = (p_msb << 1) | 8'(part[i]);
            p_lsb = p_lsb | (8'(part[i]) << i);
          end
          m_pend = 1'b1;
          part.delete();
        end
      end
    end
  endtask

  task automatic check_model();
    chk("ready_a", 32'(bit_ready_a), 32'(!m_pend));
    chk("ready_b", 32'(bit_ready_b), 32'(!m_pend));
    chk("valid_a", 32'(word_valid_a), 32'(m_ov));
    chk("valid_b", 32'(word_valid_b), 32'(m_ov));
    chk("word_a", 32'(word_out_a), 32'(m_msb));
    chk("word_b", 32'(word_out_b), 32'(m_lsb));
    chk("count_a", 32'(word_count_a), m_cnt % 4);
    chk("count_b", 32'(word_count_b), m_cnt % 65536);
  endtask

  task automatic step();
    @(negedge clk);
    check_model();
    @(posedge clk);
    model_update();
    #1;
  endtask

  task automatic send_bits(input logic [7:0] w);
    for (int i = 7; i >= 0; i--) begin
      bit_valid = 1'b1;
      bit_in    = w[i];
      step();
    end
    bit_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    bit_valid = 1'b0;
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic do_reset();
    bit_valid  = 1'b0;
    frame_sync = 1'b0;
    @(posedge clk);
    #2 rst = 1'b1;
    #1;
    chk("rst_ready", 32'(bit_ready_a), 32'd1);
    chk("rst_valid", 32'(word_valid_a), 32'd0);
    chk("rst_word", 32'(word_out_a), 32'd0);
    chk("rst_count", 32'(word_count_a), 32'd0);
    chk("rst_count_b", 32'(word_count_b), 32'd0);
    model_reset();
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
  endtask

  typedef struct {
    logic bv, bi, fs, wr;
    logic e_ready, e_valid;
    logic [7:0] e_msb, e_lsb;
    logic [15:0] e_cnt;
  } vec_t;

  vec_t tbl[11];
  logic [7:0] basic_bits;
  int wrap_exp[5];

  initial begin
    model_reset();
    basic_bits = 8'b1011_0010;
    for (int k = 0; k < 8; k++)
      tbl[k] = '{1'b1, basic_bits[7-k], 1'b0, 1'b1, 1'b1, 1'b0, 8'h00, 8'h00, 16'd0};
    tbl[8]  = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 8'h00, 8'h00, 16'd0};
    tbl[9]  = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 8'hB2, 8'h4D, 16'd1};
    tbl[10] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 8'hB2, 8'h4D, 16'd1};
    wrap_exp = '{1, 2, 3, 0, 1};

    // Power-on reset state.
    #2;
    chk("por_ready", 32'(bit_ready_a), 32'd1);
    chk("por_valid", 32'(word_valid_a), 32'd0);
    chk("por_word", 32'(word_out_b), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;

    // Basic word, both bit orders, table driven.
    for (int k = 0; k < 11; k++) begin
      bit_valid  = tbl[k].bv;
      bit_in     = tbl[k].bi;
      frame_sync = tbl[k].fs;
      word_ready = tbl[k].wr;
      @(negedge clk);
      check_model();
      chk($sformatf("tbl%0d_ready", k), 32'(bit_ready_a), 32'(tbl[k].e_ready));
      chk($sformatf("tbl%0d_valid", k), 32'(word_valid_a), 32'(tbl[k].e_valid));
      chk($sformatf("tbl%0d_msb", k), 32'(word_out_a), 32'(tbl[k].e_msb));
      chk($sformatf("tbl%0d_lsb", k), 32'(word_out_b), 32'(tbl[k].e_lsb));
      chk($sformatf("tbl%0d_cnt", k), 32'(word_count_b), 32'(tbl[k].e_cnt));
      @(posedge clk);
      model_update();
      #1;
    end

    // Back-pressure: second word stalls, first is held.
    do_reset();
    word_ready = 1'b0;
    send_bits(8'hC3);
    idle(1);
    send_bits(8'h5A);
    idle(3);
    chk("bp_ready", 32'(bit_ready_a), 32'd0);
    chk("bp_valid", 32'(word_valid_a), 32'd1);
    chk("bp_hold", 32'(word_out_a), 32'hC3);
    chk("bp_count", 32'(word_count_b), 32'd1);
    word_ready = 1'b1;
    idle(1);
    word_ready = 1'b0;
    chk("bp_word2", 32'(word_out_a), 32'h5A);
    chk("bp_valid2", 32'(word_valid_a), 32'd1);
    chk("bp_count2", 32'(word_count_b), 32'd2);

    // Reset while stalled with a word pending.
    send_bits(8'hA5);
    idle(2);
    chk("stall_ready", 32'(bit_ready_a), 32'd0);
    do_reset();

    // frame_sync mid-word with a bit accepted in the same cycle.
    word_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      bit_valid = 1'b1;
      bit_in    = 1'b1;
      step();
    end
    frame_sync = 1'b1;
    bit_in     = 1'b1;
    step();
    frame_sync = 1'b0;
    basic_bits = 8'b0100_1100;
    for (int i = 7; i >= 1; i--) begin
      bit_in = basic_bits[i];
      step();
    end
    idle(1);
    chk("fs_msb", 32'(word_out_a), 32'hA6);
    chk("fs_lsb", 32'(word_out_b), 32'h65);
    chk("fs_valid", 32'(word_valid_a), 32'd1);

    // Counter wrap on the 2-bit instance.
    do_reset();
    word_ready = 1'b1;
    for (int k = 0; k < 5; k++) begin
      send_bits(8'($urandom));
      idle(1);
      chk($sformatf("wrap%0d", k), 32'(word_count_a), 32'(wrap_exp[k]));
      chk($sformatf("wrap%0d_b", k), 32'(word_count_b), 32'(k + 1));
    end

    // Randomised traffic against the model.
    do_reset();
    for (int c = 0; c < 3000; c++) begin
      bit_valid  = ($urandom % 4) != 0;
      bit_in     = 1'($urandom);
      frame_sync = ($urandom % 40) == 0;
      word_ready = ($urandom % 3) != 0;
      step();
    end
    bit_valid  = 1'b0;
    frame_sync = 1'b0;
    step();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
